rto_dds_sequencer: RTL and testbench

Multi-channel, timestamp-driven parameter sequencer for the DAC controller family. It accepts 128-bit timed commands from the AXI-to-FIFO front end, buffers them in a parametrised FIFO, and releases each command when the 64-bit TimeController counter reaches its timestamp. Released commands update per-channel DDS register banks: frequency, amplitude, amplitude offset, phase and DAC mode. This replaces the single-channel RTO core and DDS controller pair and adds late-event tolerance, command validation and error capture.

---
 rtl/rto_dds_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_rto_dds_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rto_dds_sequencer.sv
// Timestamp-driven DDS parameter sequencer: FWFT command FIFO, fire on counter >= ts,
// one command per cycle, outputs 1 cycle after match; writes into a full FIFO are dropped and flagged.
module sync_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rptr];

   always_comb begin
      cnt_nxt = cnt;
      if (push_ok & ~pop_ok)
         cnt_nxt = cnt + (AW+1)'(1);
      else if (pop_ok & ~push_ok)
         cnt_nxt = cnt - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok & ~clr)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (push_ok)
            wptr <= wptr + AW'(1);
         if (pop_ok)
            rptr <= rptr + AW'(1);
         cnt   <= cnt_nxt;
         full  <= (cnt_nxt == (AW+1)'(DEPTH));
         empty <= (cnt_nxt == '0);
      end
   end
endmodule

module rto_dds_sequencer #(
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int LATE_TOL   = 4
) (
   input  logic                   s_axi_aclk,
   input  logic                   s_axi_aresetn,
   input  logic                   soft_reset,
   input  logic                   flush,
   input  logic                   err_clear,
   input  logic                   auto_start,
   input  logic [63:0]            counter,
   input  logic                   write,
   input  logic [127:0]           fifo_din,
   output logic                   full,
   output logic                   empty,
   output logic [NUM_CH*48-1:0]   freq,
   output logic [NUM_CH*14-1:0]   amp,
   output logic [NUM_CH*14-1:0]   amp_offset,
   output logic [NUM_CH*14-1:0]   phase,
   output logic [NUM_CH-1:0]      dac_mode,
   output logic [NUM_CH-1:0]      update,
   output logic                   timestamp_error,
   output logic                   overflow_error,
   output logic                   cmd_error,
   output logic [63:0]            timestamp_error_data,
   output logic [127:0]           overflow_error_data
);
   localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

   logic         rst_meta;
   logic         rst_n;
   logic         run;
   logic [127:0] head;
   logic [63:0]  head_ts;
   logic [3:0]   head_op;
   logic [3:0]   head_ch;
   logic [55:0]  head_data;
   logic         clr;
   logic         fire;
   logic         push;
   logic         drop;
   logic         cmd_ok;
   logic         late;
   logic         unused_bits;

   // Assert asynchronously, release two clocks after s_axi_aresetn rises.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   assign head_ts     = head[127:64];
   assign head_op     = head[63:60];
   assign head_ch     = head[59:56];
   assign head_data   = head[55:0];
   assign unused_bits = &{1'b0, head_data[55:48]};

   assign clr    = soft_reset | flush;
   assign fire   = run & ~empty & (counter >= head_ts) & ~clr;
   assign push   = write & ~full & ~clr;
   assign drop   = write & full & ~clr;
   assign cmd_ok = (head_op < 4'd4) & ({1'b0, head_ch} < NUM_CH_L);
   assign late   = (counter - head_ts) > 64'(LATE_TOL);

   sync_fifo #(
      .WIDTH (128),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (s_axi_aclk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (push),
      .pop   (fire),
      .din   (fifo_din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge s_axi_aclk or negedge rst_n) begin
      if (!rst_n) begin
         run                  <= 1'b0;
         freq                 <= '0;
         amp                  <= '0;
         amp_offset           <= '0;
         phase                <= '0;
         dac_mode             <= '0;
         update               <= '0;
         timestamp_error      <= 1'b0;
         overflow_error       <= 1'b0;
         cmd_error            <= 1'b0;
         timestamp_error_data <= '0;
         overflow_error_data  <= '0;
      end else if (soft_reset) begin
         run                  <= 1'b0;
         freq                 <= '0;
         amp                  <= '0;
         amp_offset           <= '0;
         phase                <= '0;
         dac_mode             <= '0;
         update               <= '0;
         timestamp_error      <= 1'b0;
         overflow_error       <= 1'b0;
         cmd_error            <= 1'b0;
         timestamp_error_data <= '0;
         overflow_error_data  <= '0;
      end else begin
         update <= '0;
         if (flush)
            run <= 1'b0;
         else if (auto_start)
            run <= 1'b1;

         if (fire & cmd_ok) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (head_ch == 4'(k)) begin
                  update[k] <= 1'b1;
                  case (head_op)
                     4'd0: freq[48*k +: 48] <= head_data[47:0];
                     4'd1: begin
                        amp[14*k +: 14]        <= head_data[13:0];
                        amp_offset[14*k +: 14] <= head_data[27:14];
                     end
                     4'd2: phase[14*k +: 14] <= head_data[13:0];
                     4'd3: dac_mode[k] <= head_data[0];
                     default: ;
                  endcase
               end
            end
         end

         // A new error outranks err_clear and recaptures its data.
         if (fire & late) begin
            timestamp_error <= 1'b1;
            if (!timestamp_error || err_clear)
               timestamp_error_data <= head_ts;
         end else if (err_clear) begin
            timestamp_error      <= 1'b0;
            timestamp_error_data <= '0;
         end

         if (drop) begin
            overflow_error <= 1'b1;
            if (!overflow_error || err_clear)
               overflow_error_data <= fifo_din;
         end else if (err_clear) begin
            overflow_error      <= 1'b0;
            overflow_error_data <= '0;
         end

         if (fire & ~cmd_ok)
            cmd_error <= 1'b1;
         else if (err_clear)
            cmd_error <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rto_dds_sequencer.sv
// Directed bench for rto_dds_sequencer with hand-computed expectations.
module tb_rto_dds_sequencer;
   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic         soft_reset = 1'b0;
   logic         flush = 1'b0;
   logic         err_clear = 1'b0;
   logic         auto_start = 1'b0;
   logic [63:0]  counter = '0;
   logic         write = 1'b0;
   logic [127:0] din = '0;
   logic         full;
   logic         empty;
   logic [191:0] freq;
   logic [55:0]  amp;
   logic [55:0]  amp_offset;
   logic [55:0]  phase;
   logic [3:0]   dac_mode;
   logic [3:0]   update;
   logic         timestamp_error;
   logic         overflow_error;
   logic         cmd_error;
   logic [63:0]  timestamp_error_data;
   logic [127:0] overflow_error_data;
   logic [127:0] w17;

   int n_total = 0;
   int n_bad   = 0;

   rto_dds_sequencer #(.NUM_CH(4), .FIFO_DEPTH(16), .LATE_TOL(4)) dut (
      .s_axi_aclk           (clk),
      .s_axi_aresetn        (aresetn),
      .soft_reset           (soft_reset),
      .flush                (flush),
      .err_clear            (err_clear),
      .auto_start           (auto_start),
      .counter              (counter),
      .write                (write),
      .fifo_din             (din),
      .full                 (full),
      .empty                (empty),
      .freq                 (freq),
      .amp                  (amp),
      .amp_offset           (amp_offset),
      .phase                (phase),
      .dac_mode             (dac_mode),
      .update               (update),
      .timestamp_error      (timestamp_error),
      .overflow_error       (overflow_error),
      .cmd_error            (cmd_error),
      .timestamp_error_data (timestamp_error_data),
      .overflow_error_data  (overflow_error_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] cmd(input logic [63:0] ts, input logic [3:0] op,
                                        input logic [3:0] ch, input logic [55:0] d);
      return {ts, op, ch, d};
   endfunction

   task automatic push(input logic [127:0] w);
      write = 1'b1;
      din   = w;
      step();
      write = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      aresetn = 1'b1;
      repeat (3) step();
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_freq", freq, 0);
      check("rst_err", {timestamp_error, overflow_error, cmd_error}, 0);

      // single fire
      auto_start = 1'b1;
      push(cmd(64'd100, 4'd0, 4'd1, 56'h0000_1234_5678_9ABC));
      auto_start = 1'b0;
      check("single_not_empty", empty, 0);
      counter = 64'd99;
      step();
      check("single_early", update, 4'b0000);
      counter = 64'd100;
      step();
      check("single_freq", freq[95:48], 48'h1234_5678_9ABC);
      check("single_update", update, 4'b0010);
      check("single_empty", empty, 1);
      step();
      check("single_pulse_end", update, 4'b0000);

      // burst at one timestamp
      counter = 64'd150;
      push(cmd(64'd200, 4'd1, 4'd0, {28'd0, 14'h0456, 14'h0123}));
      push(cmd(64'd200, 4'd2, 4'd0, 56'h1ABC));
      push(cmd(64'd200, 4'd3, 4'd0, 56'h1));
      counter = 64'd200;
      step();
      check("burst_amp", amp[13:0], 14'h0123);
      check("burst_off", amp_offset[13:0], 14'h0456);
      check("burst_phase_pending", phase[13:0], 0);
      counter = 64'd201;
      step();
      check("burst_phase", phase[13:0], 14'h1ABC);
      counter = 64'd202;
      step();
      check("burst_mode", dac_mode, 4'b0001);
      check("burst_empty", empty, 1);
      check("burst_no_ts_err", timestamp_error, 0);

      // late command
      counter = 64'd60;
      push(cmd(64'd50, 4'd0, 4'd2, 56'hABCD));
      step();
      check("late_freq", freq[143:96], 48'hABCD);
      check("late_err", timestamp_error, 1);
      check("late_data", timestamp_error_data, 64'd50);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("late_clr", {timestamp_error, timestamp_error_data}, 0);

      // invalid opcode and channel
      counter = 64'd300;
      push(cmd(64'd300, 4'd7, 4'd0, 56'hFFFF));
      push(cmd(64'd300, 4'd0, 4'd5, 56'h1));
      check("inv_update0", update, 4'b0000);
      step();
      check("inv_update1", update, 4'b0000);
      check("inv_empty", empty, 1);
      check("inv_cmd_err", cmd_error, 1);
      check("inv_freq0", freq[47:0], 0);
      check("inv_mode", dac_mode, 4'b0001);

      // overflow with run cleared
      flush = 1'b1;
      step();
      flush = 1'b0;
      counter = 64'd0;
      for (int i = 0; i < 15; i++)
         push(cmd(64'd1000 + 64'(i), 4'd0, 4'd0, 56'(i)));
      check("ovf_not_full15", full, 0);
      push(cmd(64'd1015, 4'd0, 4'd0, 56'd15));
      check("ovf_full16", full, 1);
      w17 = cmd(64'hDEAD, 4'h2, 4'h3, 56'h17);
      push(w17);
      check("ovf_err", overflow_error, 1);
      check("ovf_data", overflow_error_data, w17);
      check("ovf_still_full", full, 1);

      // flush keeps banks and clears run
      flush = 1'b1;
      err_clear = 1'b1;
      step();
      flush = 1'b0;
      err_clear = 1'b0;
      check("ovf_clr", overflow_error, 0);
      auto_start = 1'b1;
      for (int i = 0; i < 8; i++)
         push(cmd(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 4'd0, 56'(i)));
      auto_start = 1'b0;
      check("fl_filled", empty, 0);
      flush = 1'b1;
      write = 1'b1;
      din = cmd(64'd0, 4'd0, 4'd0, 56'h77);
      step();
      flush = 1'b0;
      write = 1'b0;
      check("fl_empty", empty, 1);
      check("fl_full", full, 0);
      check("fl_no_ovf", overflow_error, 0);
      check("fl_keep_freq", freq[95:48], 48'h1234_5678_9ABC);
      push(cmd(64'd0, 4'd0, 4'd3, 56'h5555));
      step();
      check("fl_run_off", empty, 0);
      auto_start = 1'b1;
      step();
      auto_start = 1'b0;
      step();
      check("run_fire_upd", update, 4'b1000);
      check("run_fire_freq", freq[191:144], 48'h5555);

      // async reset mid-burst
      write = 1'b1;
      din = cmd(64'd0, 4'd2, 4'd1, 56'h33);
      repeat (3) step();
      write = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      check("arst_freq", freq, 0);
      check("arst_regs", {amp, amp_offset, phase, dac_mode, update}, 0);
      check("arst_empty", empty, 1);
      check("arst_err", timestamp_error_data, 0);
      step();
      aresetn = 1'b1;
      repeat (3) step();

      // soft reset clears banks
      auto_start = 1'b1;
      push(cmd(64'd0, 4'd3, 4'd2, 56'h1));
      auto_start = 1'b0;
      step();
      check("sr_pre_mode", dac_mode, 4'b0100);
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      check("sr_mode", dac_mode, 0);
      check("sr_empty", empty, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
